// File: rtl/cacheline_burst_adaptor.sv
`default_nettype none
// ============================================================================
// Module   : cacheline_burst_adaptor
// Purpose  : Bridges a single request/response cache-line port to a beat-based
//            burst memory port. Line writebacks are split into BEATS beats.
//            Read beats are assembled into a full line. One resp_o pulse is
//            returned to the cache when a transaction finishes.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   line_i/line_o   writeback line from cache / assembled read line to cache
//   address_i       cache request byte address
//   read_i/write_i  cache line requests (level, held until resp_o)
//   resp_o          one-cycle completion pulse to cache
//   burst_i/burst_o read beat from memory / write beat to memory
//   address_o       line-aligned memory address
//   read_o/write_o  memory burst read / write request
//   resp_i          memory beat valid / accepted
// ============================================================================
module cacheline_burst_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);

  localparam int BEATS  = LINE_WIDTH / BURST_WIDTH;
  localparam int OFFSET = $clog2(LINE_WIDTH / 8);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LINE_WIDTH-1:0]   buf_q, buf_d;
  logic [LINE_WIDTH-1:0]   line_q, line_d;

  // Byte-offset bits inside a line never reach memory; the address is aligned.
  logic unused_offset_bits;
  assign unused_offset_bits = ^address_i[OFFSET-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      buf_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    line_d  = line_q;
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;
    burst_o = '0;

    unique case (state_q)
      IDLE: begin
        // Write wins when both requests are raised together.
        if (write_i || read_i) begin
          addr_d = {address_i[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
          beat_d = '0;
          if (write_i) begin
            buf_d   = line_i;
            state_d = WR_BURST;
          end else begin
            state_d = RD_BURST;
          end
        end
      end

      RD_BURST: begin
        read_o = 1'b1;
        if (resp_i) begin
          buf_d[int'(beat_q)*BURST_WIDTH +: BURST_WIDTH] = burst_i;
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) begin
            // Publish the line including the final beat so it is visible in DONE.
            line_d  = buf_d;
            state_d = DONE;
          end
        end
      end

      WR_BURST: begin
        write_o = 1'b1;
        burst_o = buf_q[int'(beat_q)*BURST_WIDTH +: BURST_WIDTH];
        if (resp_i) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        resp_o  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign address_o = addr_q;
  assign line_o    = line_q;

endmodule
`default_nettype wire

// File: tb/tb_cacheline_burst_adaptor.sv
`default_nettype none
// ============================================================================
// Module   : tb_cacheline_burst_adaptor
// Purpose  : Self-checking bench for cacheline_burst_adaptor. A burst memory
//            model answers read/write bursts; expected transactions and write
//            beats are queued by the stimulus and consumed by monitors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cacheline_burst_adaptor;

  localparam int LW = 256;
  localparam int BW = 64;
  localparam int AW = 32;

  localparam logic [LW-1:0] L_RD1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
  localparam logic [LW-1:0] L_WR1 = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
  localparam logic [LW-1:0] L_SIM = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                     64'h0F0F_0F0F_F0F0_F0F0, 64'h5A5A_A5A5_3C3C_C3C3};
  localparam logic [LW-1:0] L_ABN = {64'hDEAD_0003_0000_0003, 64'hDEAD_0002_0000_0002,
                                     64'hDEAD_0001_0000_0001, 64'hDEAD_0000_0000_0000};
  localparam logic [LW-1:0] L_RST = {64'h8888_7777_6666_5555, 64'h4444_3333_2222_1111,
                                     64'h1357_9BDF_2468_ACE0, 64'hCAFE_F00D_BEEF_0001};
  localparam logic [LW-1:0] L_B2B = {64'h0000_0000_0000_0004, 64'h0000_0000_0000_0003,
                                     64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001};

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] line_i, line_o;
  logic [AW-1:0] address_i, address_o;
  logic          read_i, write_i, resp_o;
  logic [BW-1:0] burst_i, burst_o;
  logic          read_o, write_o, resp_i;

  always #5 clk = ~clk;

  cacheline_burst_adaptor #(.LINE_WIDTH(LW), .BURST_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  typedef struct {
    bit            is_rd;
    logic [AW-1:0] addr;
    logic [LW-1:0] line;
  } txn_t;

  txn_t          exp_q[$];
  logic [BW-1:0] beat_exp[$];
  bit            pat_q[$];
  bit            spurious;
  int            checks;
  int            passed;
  logic [LW-1:0] last_rd_line;
  logic [LW-1:0] mem [logic [AW-1:0]];
  logic [1:0]    mbeat;
  logic [LW-1:0] mtmp;
  bit            mr;
  txn_t          mon_t;

  task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s", name);
  endtask

  // Burst memory model: drives resp_i/burst_i on the falling edge so they are
  // stable for the next rising edge, and checks write beats as they are offered.
  always @(negedge clk) begin
    if (rst) begin
      mbeat   = '0;
      resp_i  = 1'b0;
      burst_i = '0;
    end else if (!(read_o || write_o)) begin
      mbeat   = '0;
      resp_i  = spurious;
      burst_i = '0;
    end else begin
      mr = 1'b1;
      if (pat_q.size() > 0) mr = pat_q.pop_front();
      resp_i = mr;
      chk("rd_wr_exclusive", {255'd0, read_o & write_o}, '0);
      mtmp = mem.exists(address_o) ? mem[address_o] : '0;
      if (read_o) burst_i = mtmp[BW*mbeat +: BW];
      if (write_o) begin
        if (beat_exp.size() == 0) fail_now("write_beat_unexpected");
        else chk("burst_o", {192'd0, burst_o}, {192'd0, beat_exp[0]});
        if (mr) begin
          if (beat_exp.size() > 0) void'(beat_exp.pop_front());
          mtmp[BW*mbeat +: BW] = burst_o;
          mem[address_o] = mtmp;
        end
      end
      if (mr) mbeat = mbeat + 2'd1;
    end
  end

  // Response monitor: pops the scoreboard on every resp_o pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (read_o && exp_q.size() > 0 && !exp_q[0].is_rd)
        fail_now("read_o_during_write");
      if (resp_o) begin
        if (exp_q.size() == 0) begin
          fail_now("resp_o_unexpected");
        end else begin
          mon_t = exp_q.pop_front();
          chk("address_o", {224'd0, address_o}, {224'd0, mon_t.addr});
          chk("req_dropped_in_done", {254'd0, read_o, write_o}, '0);
          if (mon_t.is_rd) begin
            chk("line_o", line_o, mon_t.line);
            last_rd_line = mon_t.line;
          end else begin
            chk("line_o_unchanged_by_write", line_o, last_rd_line);
            chk("write_beats_remaining", LW'(beat_exp.size()), '0);
          end
        end
      end
    end
  end

  task automatic wait_resp(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (resp_o) got = 1'b1;
    end
    if (!got) fail_now({name, "_resp_timeout"});
    @(posedge clk);
    #1;
  endtask

  task automatic push_write(input logic [AW-1:0] aaddr, input logic [LW-1:0] line);
    txn_t t;
    t.is_rd = 1'b0;
    t.addr  = aaddr;
    t.line  = line;
    exp_q.push_back(t);
    for (int i = 0; i < LW/BW; i++) beat_exp.push_back(line[BW*i +: BW]);
  endtask

  task automatic push_read(input logic [AW-1:0] aaddr, input logic [LW-1:0] line);
    txn_t t;
    t.is_rd = 1'b1;
    t.addr  = aaddr;
    t.line  = line;
    exp_q.push_back(t);
  endtask

  task automatic txn(input bit rd, input logic [AW-1:0] addr, input logic [AW-1:0] aaddr,
                     input logic [LW-1:0] line, input string name);
    address_i = addr;
    line_i    = rd ? '0 : line;
    if (rd) push_read(aaddr, line);
    else    push_write(aaddr, line);
    read_i  = rd;
    write_i = !rd;
    wait_resp(name);
    read_i  = 1'b0;
    write_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    checks = 0; passed = 0; spurious = 1'b0; last_rd_line = '0;
    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; address_i = '0; line_i = '0;
    resp_i = 1'b0; burst_i = '0;
    mem[32'h0000_1220] = L_RD1;
    mem[32'h0000_0080] = L_ABN;
    mem[32'h0000_00A0] = L_RST;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_read_o",    {255'd0, read_o},  '0);
    chk("rst_write_o",   {255'd0, write_o}, '0);
    chk("rst_resp_o",    {255'd0, resp_o},  '0);
    chk("rst_address_o", {224'd0, address_o}, '0);
    chk("rst_burst_o",   {192'd0, burst_o}, '0);
    chk("rst_line_o",    line_o, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Plain read, unaligned address.
    txn(1'b1, 32'h0000_1234, 32'h0000_1220, L_RD1, "read1");

    // Write with stalls on the memory side.
    pat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    txn(1'b0, 32'h0000_0104, 32'h0000_0100, L_WR1, "write_stall");

    // Simultaneous requests: write first, then the held read returns it.
    address_i = 32'h0000_0210;
    line_i    = L_SIM;
    push_write(32'h0000_0200, L_SIM);
    read_i  = 1'b1;
    write_i = 1'b1;
    wait_resp("simul_write");
    write_i = 1'b0;
    push_read(32'h0000_0200, L_SIM);
    wait_resp("simul_read");
    read_i = 1'b0;

    // Reset in the middle of a read after two beats.
    address_i = 32'h0000_0088;
    push_read(32'h0000_0080, L_ABN);
    read_i = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_read_o",  {255'd0, read_o},  '0);
    chk("midrst_resp_o",  {255'd0, resp_o},  '0);
    chk("midrst_write_o", {255'd0, write_o}, '0);
    chk("midrst_line_o",  line_o, '0);
    exp_q.delete();
    last_rd_line = '0;
    read_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    txn(1'b1, 32'h0000_00B8, 32'h0000_00A0, L_RST, "read_after_rst");

    // Write then read same line, with spurious memory responses while idle.
    txn(1'b0, 32'h0000_0040, 32'h0000_0040, L_B2B, "b2b_write");
    spurious = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_spur_read_o",    {255'd0, read_o},  '0);
      chk("idle_spur_write_o",   {255'd0, write_o}, '0);
      chk("idle_spur_resp_o",    {255'd0, resp_o},  '0);
      chk("idle_spur_address_o", {224'd0, address_o}, {224'd0, 32'h0000_0040});
    end
    spurious = 1'b0;
    @(posedge clk);
    #1;
    txn(1'b1, 32'h0000_0040, 32'h0000_0040, L_B2B, "b2b_read");

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", LW'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
